// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce, per-button press/auto-repeat FSM
// and a lowest-index-first arbiter that emits at most one event pulse per cycle.
module button_conditioner #(
  parameter int unsigned        NUM_BTN         = 5,
  parameter int unsigned        DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned        REPEAT_DELAY    = 50_000_000,
  parameter int unsigned        REPEAT_RATE     = 10_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(5'b11110)
) (
  input  logic               clk_100mhz,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_pending
);

  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0]  DbMax     = '1;
  localparam logic [RepW-1:0] DelayLoad = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RateLoad  = RepW'(REPEAT_RATE - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeld   = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [DbW-1:0]     db_cnt_q [NUM_BTN];
  logic [DbW-1:0]     db_cnt_d [NUM_BTN];
  logic [1:0]         state_q  [NUM_BTN];
  logic [1:0]         state_d  [NUM_BTN];
  logic [RepW-1:0]    rep_q    [NUM_BTN];
  logic [RepW-1:0]    rep_d    [NUM_BTN];
  logic [NUM_BTN-1:0] event_v;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] grant;

  // Level toggles once the synced input has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
        end else if (db_cnt_q[i] != DbMax) begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end else begin
          db_cnt_d[i] = db_cnt_q[i];
        end
      end
    end
  end

  always_comb begin
    event_v = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      rep_d[i]   = rep_q[i];
      if (!level_q[i]) begin
        state_d[i] = StIdle;
        rep_d[i]   = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            state_d[i] = StHeld;
            rep_d[i]   = DelayLoad;
            event_v[i] = 1'b1;
          end
          StHeld: begin
            if (REPEAT_MASK[i]) begin
              if (rep_q[i] == '0) begin
                state_d[i] = StRepeat;
                rep_d[i]   = RateLoad;
                event_v[i] = 1'b1;
              end else begin
                rep_d[i] = rep_q[i] - RepW'(1);
              end
            end
          end
          StRepeat: begin
            if (rep_q[i] == '0) begin
              rep_d[i]   = RateLoad;
              event_v[i] = 1'b1;
            end else begin
              rep_d[i] = rep_q[i] - RepW'(1);
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  // Isolate the lowest set pending bit; an event landing on the granted bit re-arms it.
  always_comb begin
    grant     = pending_q & (~pending_q + NUM_BTN'(1));
    pending_d = (pending_q & ~grant) | event_v;
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= StIdle;
        rep_q[i]    <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
        rep_q[i]    <= rep_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_pulse   = grant;
  assign btn_pending = pending_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations plus randomized
// button activity checked every cycle against a behavioural model.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam logic [NB-1:0] MASK = 5'b11110;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_pulse, btn_pending;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk_100mhz  (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_pending (btn_pending)
  );

  int checks = 0;
  int errors = 0;

  // Model state: n = clock edges since reset release; values describe the current cycle.
  int            n = 0;
  logic [NB-1:0] m_s1 = '0, m_sync = '0, m_lvl = '0, m_lvl_prev = '0, m_pend = '0;
  logic [NB-1:0] m_ev, m_nl;
  int            run   [NB];
  int            press [NB];
  int            rise  [NB];
  int            hold  [NB];
  int            log_cyc [$];
  logic [NB-1:0] log_pat [$];

  function automatic logic [NB-1:0] lowest(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    bit            found;
    r = '0;
    found = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (v[b] && !found) begin
        r[b]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, n, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: debounce as a run of disagreeing synced samples, repeats as
  // arithmetic on the press time, and a pending set drained lowest bit first.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      n = 0;
      m_s1 = '0; m_sync = '0; m_lvl = '0; m_lvl_prev = '0; m_pend = '0;
      for (int b = 0; b < NB; b++) begin
        run[b]   = 0;
        press[b] = 0;
      end
    end else begin
      n++;
      m_ev = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_lvl[b]) begin
          if (!m_lvl_prev[b]) begin
            m_ev[b]  = 1'b1;
            press[b] = n;
          end else if (MASK[b] && (n - press[b]) >= RD && ((n - press[b] - RD) % RR) == 0) begin
            m_ev[b] = 1'b1;
          end
        end
      end
      m_pend = (m_pend & ~lowest(m_pend)) | m_ev;
      m_nl = m_lvl;
      for (int b = 0; b < NB; b++) begin
        if (m_sync[b] != m_lvl[b]) begin
          run[b]++;
          if (run[b] == DC) begin
            m_nl[b] = ~m_lvl[b];
            run[b]  = 0;
          end
        end else begin
          run[b] = 0;
        end
      end
      m_sync     = m_s1;
      m_s1       = btn_raw;
      m_lvl_prev = m_lvl;
      m_lvl      = m_nl;
    end
  end

  // Per-cycle comparison, plus a log of pulses and first level rise for directed checks.
  initial forever begin
    @(posedge clk);
    #1;
    chk("level", btn_level, m_lvl);
    chk("pulse", btn_pulse, lowest(m_pend));
    chk("pending", btn_pending, m_pend);
    if (reset_n && btn_pulse != '0) begin
      log_cyc.push_back(n);
      log_pat.push_back(btn_pulse);
    end
    for (int b = 0; b < NB; b++) begin
      if (btn_level[b] && rise[b] < 0) rise[b] = n;
    end
  end

  // Asserts reset immediately; returns at a falling edge with reset released (cycle 0).
  task automatic apply_reset(input logic [NB-1:0] raw);
    reset_n = 1'b0;
    btn_raw = raw;
    #1;
    chk("rst level", btn_level, '0);
    chk("rst pulse", btn_pulse, '0);
    chk("rst pending", btn_pending, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    log_cyc.delete();
    log_pat.delete();
    for (int b = 0; b < NB; b++) rise[b] = -1;
  endtask

  task automatic run_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int exp_cyc [6];
    exp_cyc = '{7, 27, 35, 43, 51, 59};

    // 1: all buttons held through reset release
    apply_reset(5'b11111);
    run_cycles(12);
    for (int b = 0; b < NB; b++) chk_int("t1 rise", rise[b], 6);
    chk_int("t1 npulse", log_cyc.size(), 5);
    for (int i = 0; i < 5 && i < log_cyc.size(); i++) begin
      chk_int("t1 pcyc", log_cyc[i], 7 + i);
      chk("t1 ppat", log_pat[i], lowest(5'b11111 << i));
    end

    // 2: 3-cycle glitch on btnd is rejected
    apply_reset('0);
    btn_raw = 5'b00100;
    run_cycles(3);
    btn_raw = '0;
    run_cycles(20);
    chk_int("t2 npulse", log_cyc.size(), 0);
    chk_int("t2 rise", rise[2], -1);

    // 3: btnd steady high
    apply_reset(5'b00100);
    run_cycles(15);
    chk_int("t3 rise", rise[2], 6);
    chk_int("t3 npulse", log_cyc.size(), 1);
    if (log_cyc.size() > 0) begin
      chk_int("t3 pcyc", log_cyc[0], 7);
      chk("t3 ppat", log_pat[0], 5'b00100);
    end

    // 4: btnu auto-repeats, btnc does not
    apply_reset(5'b00010);
    run_cycles(60);
    btn_raw = '0;
    run_cycles(30);
    chk_int("t4u npulse", log_cyc.size(), 6);
    for (int i = 0; i < 6 && i < log_cyc.size(); i++) begin
      chk_int("t4u pcyc", log_cyc[i], exp_cyc[i]);
      chk("t4u ppat", log_pat[i], 5'b00010);
    end
    apply_reset(5'b00001);
    run_cycles(60);
    btn_raw = '0;
    run_cycles(20);
    chk_int("t4c npulse", log_cyc.size(), 1);
    if (log_cyc.size() > 0) chk_int("t4c pcyc", log_cyc[0], 7);

    // 5: btnc and btnl together
    apply_reset(5'b01001);
    run_cycles(12);
    btn_raw = '0;
    run_cycles(15);
    chk_int("t5 npulse", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      chk_int("t5 pcyc0", log_cyc[0], 7);
      chk("t5 ppat0", log_pat[0], 5'b00001);
      chk_int("t5 pcyc1", log_cyc[1], 8);
      chk("t5 ppat1", log_pat[1], 5'b01000);
    end

    // 6: reset while btnl waits behind btnc
    apply_reset(5'b01001);
    run_cycles(7);
    chk("t6 pending", btn_pending, 5'b01001);
    chk("t6 pulse", btn_pulse, 5'b00001);
    apply_reset('0);
    run_cycles(20);
    chk_int("t6 npulse", log_cyc.size(), 0);
    chk("t6 pend after", btn_pending, '0);

    // Randomized activity with glitches, long holds and occasional mid-run resets
    apply_reset(NB'($urandom));
    for (int b = 0; b < NB; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        apply_reset(NB'($urandom));
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (hold[b] == 0) begin
            btn_raw[b] = ~btn_raw[b];
            hold[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                  : int'($urandom_range(6, 90));
          end else begin
            hold[b]--;
          end
        end
        @(negedge clk);
      end
    end
    btn_raw = '0;
    run_cycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
